// File: rtl/sdram_init_refresh_ctrl_if.sv
// Command-bus and refresh-handshake bundle between the init/refresh sequencer and the scheduler side.
// Latency: none; this is wiring only.
// Backpressure: the scheduler holds off refreshes by withholding ref_gnt while ref_req is high.
interface sdram_init_refresh_ctrl_if;
  logic [12:0] cfg_mode_reg;
  logic        ref_gnt;
  logic        sdr_cke;
  logic        sdr_cs_n;
  logic        sdr_ras_n;
  logic        sdr_cas_n;
  logic        sdr_we_n;
  logic [12:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic        sdr_init_done;
  logic        ref_req;
  logic        cmd_own;
  logic        ref_ovf;

  // Sequencer side: drives the SDRAM command bus and the refresh request.
  modport master (
    input  cfg_mode_reg, ref_gnt,
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    output sdr_addr, sdr_ba, sdr_init_done, ref_req, cmd_own, ref_ovf
  );

  // Scheduler side: supplies the mode value and grants refreshes.
  modport slave (
    output cfg_mode_reg, ref_gnt,
    input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    input  sdr_addr, sdr_ba, sdr_init_done, ref_req, cmd_own, ref_ovf
  );
endinterface

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up init (PRE, N x AUTO REFRESH, LMR) and periodic auto-refresh sequencer.
// Latency: all outputs registered; a grant sampled at edge g puts PRECHARGE on the bus at g+1.
// Backpressure: refreshes wait in a saturating pending counter until ref_gnt; lost ticks set ref_ovf.
module sdram_init_refresh_ctrl #(
  parameter int INIT_WAIT    = 500,
  parameter int TRP          = 2,
  parameter int TRFC         = 7,
  parameter int TMRD         = 2,
  parameter int INIT_REFRESH = 2,
  parameter int REF_INTERVAL = 780,
  parameter int MAX_PEND     = 8
) (
  input  logic                        sdram_clk,
  input  logic                        sdram_resetn,
  sdram_init_refresh_ctrl_if.master   bus
);

  // Command encodings as {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // One shared down-counter covers every wait state, so size it for the longest wait.
  localparam int WMAX0 = (INIT_WAIT > TRP)  ? INIT_WAIT : TRP;
  localparam int WMAX1 = (WMAX0 > TRFC)     ? WMAX0     : TRFC;
  localparam int WMAX  = (WMAX1 > TMRD)     ? WMAX1     : TMRD;
  localparam int CW    = $clog2(WMAX + 1);
  localparam int RW    = $clog2(INIT_REFRESH + 1);
  localparam int IW    = $clog2(REF_INTERVAL);

  // Wait-state reload values: the command cycle itself counts as the first cycle of the spacing.
  localparam int TRP_WAIT  = (TRP  > 1) ? TRP  - 2 : 0;
  localparam int TRFC_WAIT = (TRFC > 1) ? TRFC - 2 : 0;
  localparam int TMRD_WAIT = (TMRD > 1) ? TMRD - 2 : 0;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_PRE,
    S_TRP_W,
    S_REF,
    S_TRFC_W,
    S_LMR,
    S_MRD_W,
    S_IDLE,
    S_GNT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [RW-1:0]   iref_q, iref_d;
  logic            done_q, done_d;
  logic            own_q, own_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [12:0]     addr_q, addr_d;
  logic [1:0]      ba_q, ba_d;
  logic            cke_q;
  logic            req_q;
  logic            ovf_q;
  logic [3:0]      pend_q;
  logic [IW-1:0]   ivl_q;
  logic            trfc_end;
  logic            tick;
  logic            ref_dec;

  // Next-state and next-command decode; command states last exactly one cycle, so the
  // registered command is a pure function of the state being entered.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    iref_d   = iref_q;
    done_d   = done_q;
    own_d    = own_q;
    trfc_end = 1'b0;
    cmd_d    = CMD_NOP;
    addr_d   = '0;
    ba_d     = '0;

    case (state_q)
      S_PWRUP: begin
        if (wait_q == '0) state_d = S_PRE;
        else              wait_d  = wait_q - 1'b1;
      end
      S_PRE: begin
        if (TRP > 1) begin
          state_d = S_TRP_W;
          wait_d  = CW'(TRP_WAIT);
        end else begin
          state_d = S_REF;
        end
      end
      S_TRP_W: begin
        if (wait_q == '0) state_d = S_REF;
        else              wait_d  = wait_q - 1'b1;
      end
      S_REF: begin
        if (TRFC > 1) begin
          state_d = S_TRFC_W;
          wait_d  = CW'(TRFC_WAIT);
        end else begin
          trfc_end = 1'b1;
        end
      end
      S_TRFC_W: begin
        if (wait_q == '0) trfc_end = 1'b1;
        else              wait_d   = wait_q - 1'b1;
      end
      S_LMR: begin
        if (TMRD > 1) begin
          state_d = S_MRD_W;
          wait_d  = CW'(TMRD_WAIT);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          own_d   = 1'b0;
        end
      end
      S_MRD_W: begin
        if (wait_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          own_d   = 1'b0;
        end else begin
          wait_d  = wait_q - 1'b1;
        end
      end
      S_IDLE: begin
        // Grant only counts while a request is visible to the scheduler.
        if (req_q && bus.ref_gnt) state_d = S_GNT;
      end
      S_GNT: begin
        // Take the bus together with the PRECHARGE one cycle after the grant edge.
        state_d = S_PRE;
        own_d   = 1'b1;
      end
      default: state_d = S_PWRUP;
    endcase

    // End of tRFC: init loops through the remaining refreshes, run-time goes back to IDLE.
    if (trfc_end) begin
      if (done_q) begin
        state_d = S_IDLE;
        own_d   = 1'b0;
      end else if (iref_q == RW'(INIT_REFRESH)) begin
        state_d = S_LMR;
      end else begin
        state_d = S_REF;
      end
    end

    if ((state_d == S_REF) && !done_q) iref_d = iref_q + 1'b1;

    case (state_d)
      S_PRE: begin
        cmd_d      = CMD_PRE;
        addr_d[10] = 1'b1;
      end
      S_REF: cmd_d = CMD_REF;
      S_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = bus.cfg_mode_reg;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  // Sequencer state, wait counter and registered command bus.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q <= S_PWRUP;
      wait_q  <= CW'(INIT_WAIT);
      iref_q  <= '0;
      done_q  <= 1'b0;
      own_q   <= 1'b1;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      iref_q  <= iref_d;
      done_q  <= done_d;
      own_q   <= own_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      cke_q   <= 1'b1;
    end
  end

  // A tick fires on the cycle the interval counter sits at zero; a run-time REF consumes one.
  assign tick    = done_q && (ivl_q == '0);
  assign ref_dec = done_q && (state_d == S_REF);

  // Refresh interval timer, free-running once init has completed.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      ivl_q <= IW'(REF_INTERVAL - 1);
    end else if (done_q) begin
      if (ivl_q == '0) ivl_q <= IW'(REF_INTERVAL - 1);
      else             ivl_q <= ivl_q - 1'b1;
    end
  end

  // Saturating pending-refresh counter with sticky overflow on a lost tick.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case ({tick, ref_dec})
        2'b10: begin
          if (pend_q == 4'(MAX_PEND)) ovf_q  <= 1'b1;
          else                        pend_q <= pend_q + 1'b1;
        end
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  // Request is only advertised while parked in IDLE so a grant cannot race an active sequence.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) req_q <= 1'b0;
    else               req_q <= (pend_q != '0) && (state_q == S_IDLE);
  end

  assign bus.sdr_cke       = cke_q;
  assign bus.sdr_cs_n      = cmd_q[3];
  assign bus.sdr_ras_n     = cmd_q[2];
  assign bus.sdr_cas_n     = cmd_q[1];
  assign bus.sdr_we_n      = cmd_q[0];
  assign bus.sdr_addr      = addr_q;
  assign bus.sdr_ba        = ba_q;
  assign bus.sdr_init_done = done_q;
  assign bus.ref_req       = req_q;
  assign bus.cmd_own       = own_q;
  assign bus.ref_ovf       = ovf_q;

endmodule
